vga_line_fetcher: RTL and testbench

Frame-buffer fetch scheduler feeding the pixel FIFO that sits in front of `vga`. It tracks the raster position from `vga`'s `beam_x`/`beam_y` and issues burst read requests to the memory arbiter. Requests are paced by FIFO free-space credits, so the FIFO always holds the next pixels before `fetch_next` consumes them. It sits between the memory arbiter, the pixel FIFO and `vga`, all on the pixel clock.

---
 rtl/vga_line_fetcher.sv | 182 ++++++++++++++++++
 tb/tb_vga_line_fetcher.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_line_fetcher.sv
`default_nettype none
// ============================================================================
// Module  : vga_line_fetcher
// Purpose : Frame-buffer fetch scheduler for the pixel FIFO in front of vga.
//           Follows the raster and issues burst reads to the memory arbiter.
//           A burst is only requested when the FIFO has room for all of it.
//           Fetching of a frame starts at the first vblank pixel.
// Ports   : clk_pixel, rst_n        - pixel clock, async active-low reset
//           enable, fb_base         - scanout enable / base word address,
//                                     both taken at frame start
//           beam_x, beam_y          - raster position from vga
//           fifo_free, fifo_flush   - FIFO free words / discard pulse
//           mem_req/addr/ack/valid  - burst read handshake and beat strobe
//           busy, frame_late        - not idle / frame overran its fetch
// Config  : VGA_LINE_REPEAT_EN - each source line is fetched twice
//           (Y double-scan), so a frame reads half as many source lines.
// Revision: 1.0 - initial release
// ============================================================================
module vga_line_fetcher #(
  parameter int C_resolution_x = 640,
  parameter int C_resolution_y = 480,
  parameter int C_pitch        = 640,
  parameter int C_burst        = 16,
  parameter int C_addr_bits    = 24
) (
  input  logic                   clk_pixel,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [C_addr_bits-1:0] fb_base,
  input  logic [11:0]            beam_x,
  input  logic [10:0]            beam_y,
  input  logic [10:0]            fifo_free,
  output logic                   fifo_flush,
  output logic                   mem_req,
  output logic [C_addr_bits-1:0] mem_addr,
  input  logic                   mem_ack,
  input  logic                   mem_valid,
  output logic                   busy,
  output logic                   frame_late
);

  localparam int BEAT_W = $clog2(C_burst + 1);

  localparam logic [11:0]            BURST_X   = 12'(C_burst);
  localparam logic [11:0]            RES_X     = 12'(C_resolution_x);
  localparam logic [10:0]            RES_Y     = 11'(C_resolution_y);
  localparam logic [10:0]            BURST_FREE = 11'(C_burst);
  localparam logic [C_addr_bits-1:0] PITCH     = C_addr_bits'(C_pitch);
  localparam logic [BEAT_W-1:0]      BEAT_LAST = BEAT_W'(C_burst - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FLUSH = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_REQ   = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]             state;
  logic [2:0]             next_state;
  logic                   fs;
  logic                   restart_pending;
  logic [C_addr_bits-1:0] line_addr;
  logic [11:0]            x_off;
  logic [10:0]            line_cnt;
  logic [BEAT_W-1:0]      beat_cnt;

  logic credit;
  logic last_beat;
  logic line_end;
  logic frame_end;
  logic flush_d;
  logic req_d;
  logic busy_d;
  logic late_d;

  assign credit    = (fifo_free >= BURST_FREE);
  assign last_beat = (state == S_DATA) && mem_valid && (beat_cnt == BEAT_LAST);
  assign line_end  = ((x_off + BURST_X) == RES_X);
  assign frame_end = line_end && ((line_cnt + 11'd1) == RES_Y);

  // State register
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (fs && enable) next_state = S_FLUSH;
      S_FLUSH: next_state = S_CHECK;
      S_CHECK: begin
        if (fs)          next_state = S_FLUSH;
        else if (credit) next_state = S_REQ;
      end
      S_REQ:   if (mem_ack) next_state = S_DATA;
      S_DATA: begin
        if (last_beat) begin
          // A frame start seen during the burst (including on this very
          // beat) wins over the normal line/frame progression.
          if (restart_pending || fs) next_state = enable ? S_FLUSH : S_IDLE;
          else if (frame_end)        next_state = S_DONE;
          else                       next_state = S_CHECK;
        end
      end
      S_DONE:  if (fs) next_state = enable ? S_FLUSH : S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Output logic: outputs are registered from the next state so that each
  // one is valid in the same cycle as the state it belongs to.
  always_comb begin
    flush_d = (next_state == S_FLUSH);
    req_d   = (next_state == S_REQ);
    busy_d  = (next_state != S_IDLE);
    late_d  = fs && ((state == S_CHECK) || (state == S_REQ) || (state == S_DATA));
  end

  // Datapath and registered outputs
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      fs              <= 1'b0;
      fifo_flush      <= 1'b0;
      mem_req         <= 1'b0;
      busy            <= 1'b0;
      frame_late      <= 1'b0;
      mem_addr        <= '0;
      restart_pending <= 1'b0;
      line_addr       <= '0;
      x_off           <= '0;
      line_cnt        <= '0;
      beat_cnt        <= '0;
    end else begin
      fs         <= (beam_x == 12'd0) && (beam_y == RES_Y);
      fifo_flush <= flush_d;
      mem_req    <= req_d;
      busy       <= busy_d;
      frame_late <= late_d;

      case (state)
        S_FLUSH: begin
          line_addr       <= fb_base;
          x_off           <= '0;
          line_cnt        <= '0;
          restart_pending <= 1'b0;
        end
        S_CHECK: begin
          if (!fs && credit)
            mem_addr <= line_addr + {{(C_addr_bits-12){1'b0}}, x_off};
        end
        S_REQ: begin
          if (fs)      restart_pending <= 1'b1;
          if (mem_ack) beat_cnt <= '0;
        end
        S_DATA: begin
          if (fs)        restart_pending <= 1'b1;
          if (mem_valid) beat_cnt <= beat_cnt + BEAT_W'(1);
          if (last_beat) begin
            restart_pending <= 1'b0;
            if (line_end) begin
              x_off    <= '0;
              line_cnt <= line_cnt + 11'd1;
`ifdef VGA_LINE_REPEAT_EN
              // Odd output line finishes a source line pair.
              if (line_cnt[0]) line_addr <= line_addr + PITCH;
`else
              line_addr <= line_addr + PITCH;
`endif
            end else begin
              x_off <= x_off + BURST_X;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_line_fetcher.sv
`default_nettype none
// ============================================================================
// Module  : tb_vga_line_fetcher
// Purpose : Self-checking bench for vga_line_fetcher with a reduced raster
//           (64x6 visible, 100x10 total) so whole frames fit in a short run.
//           A burst-level address model checks every request; directed
//           sequences cover latency, credit stall, late frame start, address
//           wrap, disable and asynchronous reset.
// Revision: 1.0 - initial release
// ============================================================================
module tb_vga_line_fetcher;

  localparam int X       = 64;
  localparam int Y       = 6;
  localparam int PITCH   = 640;
  localparam int B       = 16;
  localparam int AW      = 24;
  localparam int BPL     = X / B;
  localparam int BPF     = BPL * Y;
  localparam int H_TOTAL = 100;
  localparam int V_TOTAL = 10;

  logic          clk_pixel;
  logic          rst_n;
  logic          enable;
  logic [AW-1:0] fb_base;
  logic [11:0]   beam_x;
  logic [10:0]   beam_y;
  logic [10:0]   fifo_free;
  logic          fifo_flush;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic          mem_valid;
  logic          busy;
  logic          frame_late;

  vga_line_fetcher #(
    .C_resolution_x(X), .C_resolution_y(Y), .C_pitch(PITCH),
    .C_burst(B), .C_addr_bits(AW)
  ) dut (
    .clk_pixel(clk_pixel), .rst_n(rst_n), .enable(enable), .fb_base(fb_base),
    .beam_x(beam_x), .beam_y(beam_y), .fifo_free(fifo_free),
    .fifo_flush(fifo_flush), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_valid(mem_valid), .busy(busy),
    .frame_late(frame_late)
  );

  initial clk_pixel = 1'b0;
  always #5 clk_pixel = ~clk_pixel;

  int checks = 0;
  int passes = 0;

  task automatic check(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  // Address of burst k of a frame starting at base, from raster geometry.
  function automatic logic [AW-1:0] exp_addr(input logic [AW-1:0] base, input int k);
    int line, src, xo;
    logic [31:0] full;
    line = k / BPL;
    xo   = (k % BPL) * B;
`ifdef VGA_LINE_REPEAT_EN
    src  = line / 2;
`else
    src  = line;
`endif
    full = 32'(base) + 32'(src * PITCH) + 32'(xo);
    return full[AW-1:0];
  endfunction

  // ---------------- raster generator ----------------
  int jump_tok = 0;
  initial begin
    int last_tok;
    last_tok = 0;
    beam_x = 12'd0;
    beam_y = 11'd0;
    forever begin
      @(negedge clk_pixel);
      if (jump_tok != last_tok) begin
        last_tok = jump_tok;
        beam_x   = 12'd0;
        beam_y   = 11'(Y);
      end else if (beam_x == 12'(H_TOTAL - 1)) begin
        beam_x = 12'd0;
        beam_y = (beam_y == 11'(V_TOTAL - 1)) ? 11'd0 : beam_y + 11'd1;
      end else begin
        beam_x = beam_x + 12'd1;
      end
    end
  end

  // ---------------- memory responder ----------------
  int ack_dly     = 3;
  int total_beats = 0;
  initial begin
    int rs, cnt, beats;
    rs = 0; cnt = 0; beats = 0;
    mem_ack = 1'b0;
    mem_valid = 1'b0;
    forever begin
      @(negedge clk_pixel);
      mem_ack   = 1'b0;
      mem_valid = 1'b0;
      if (!rst_n) begin
        rs = 0; cnt = 0; beats = 0;
      end else if (rs == 0) begin
        if (mem_req) begin
          cnt++;
          if (cnt >= ack_dly) begin
            mem_ack = 1'b1; rs = 1; cnt = 0; beats = 0;
          end
        end else begin
          cnt = 0;
        end
      end else begin
        mem_valid = 1'b1;
        beats++;
        total_beats++;
        if (beats == B) rs = 0;
      end
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  int            k = 0;
  int            flush_cnt = 0;
  int            late_cnt = 0;
  int            req_seq = 0;
  logic [AW-1:0] last_req_addr = '0;
  initial begin
    bit            prev_req, frame_open, late_in_frame;
    logic [AW-1:0] prev_addr, m_base;
    prev_req = 0; frame_open = 0; late_in_frame = 0;
    prev_addr = '0; m_base = '0;
    forever begin
      @(posedge clk_pixel);
      #1;
      if (!rst_n) begin
        check(!mem_req && !busy && mem_addr == '0 && !fifo_flush && !frame_late,
              "reset_outputs", {mem_addr, mem_req, busy, fifo_flush, frame_late}, 32'h0);
        prev_req = 0; frame_open = 0; late_in_frame = 0; k = 0;
      end else begin
        if (frame_late) begin
          late_cnt++;
          late_in_frame = 1;
        end
        if (fifo_flush) begin
          flush_cnt++;
          if (frame_open && !late_in_frame)
            check(k == BPF, "bursts_per_frame", k, BPF);
          frame_open = 1; late_in_frame = 0; k = 0; m_base = fb_base;
        end
        if (mem_req && !prev_req) begin
          check(mem_addr == exp_addr(m_base, k), "burst_addr", mem_addr, exp_addr(m_base, k));
          last_req_addr = mem_addr;
          req_seq++;
          k++;
        end else if (mem_req && prev_req) begin
          check(mem_addr == prev_addr, "addr_stable", mem_addr, prev_addr);
        end
        if (prev_req && !mem_req)
          check(mem_ack == 1'b1, "req_held_until_ack", mem_ack, 1);
        if (mem_req)
          check(busy == 1'b1, "req_implies_busy", busy, 1);
        prev_req  = mem_req;
        prev_addr = mem_addr;
      end
    end
  end

  // ---------------- helpers for the directed sequence ----------------
  task automatic wait_flush(input int bound, output bit ok);
    int s;
    s = flush_cnt;
    ok = 0;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk_pixel);
      #2;
      if (flush_cnt != s) begin ok = 1; return; end
    end
  endtask

  task automatic wait_next_req(input int bound, output logic [AW-1:0] a, output bit ok);
    int s;
    s = req_seq;
    ok = 0;
    a = '0;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk_pixel);
      #2;
      if (req_seq != s) begin ok = 1; a = last_req_addr; return; end
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit            ok;
    logic [AW-1:0] a;
    int            t0, bad, fc;
    logic [AW-1:0] exp5;

    rst_n = 1'b0; enable = 1'b1; fb_base = 24'h001000; fifo_free = 11'd1024;
    repeat (3) @(posedge clk_pixel);
    #2;
    check(mem_req == 1'b0 && busy == 1'b0 && mem_addr == '0, "reset_state",
          {mem_addr, mem_req, busy}, 32'h0);
    @(negedge clk_pixel);
    rst_n = 1'b1;

    // Normal frame: flush, two-cycle request latency, address sequence.
    wait_flush(2000, ok);
    check(ok, "first_flush_seen", ok, 1);
    @(posedge clk_pixel); #2;
    check(mem_req == 1'b0, "req_latency_c1", mem_req, 0);
    @(posedge clk_pixel); #2;
    check(mem_req == 1'b1 && mem_addr == 24'h001000, "req_latency_c2", {mem_req, mem_addr}, {1'b1, 24'h001000});
    wait_next_req(200, a, ok);
    check(ok && a == 24'h001010, "addr_burst1", a, 24'h001010);
    wait_next_req(200, a, ok);
    check(ok && a == 24'h001020, "addr_burst2", a, 24'h001020);
    wait_next_req(200, a, ok);
    check(ok && a == 24'h001030, "addr_burst3", a, 24'h001030);
    wait_next_req(200, a, ok);
`ifdef VGA_LINE_REPEAT_EN
    exp5 = 24'h001000;
`else
    exp5 = 24'h001280;
`endif
    check(ok && a == exp5, "addr_line1_start", a, exp5);
    wait_flush(2000, ok);
    check(ok, "second_flush_seen", ok, 1);
    check(late_cnt == 0, "no_late_normal", late_cnt, 0);

    // Credit stall: no request while free space is below one burst.
    wait_next_req(200, a, ok);
    t0 = total_beats;
    @(negedge clk_pixel);
    fifo_free = 11'd8;
    for (int i = 0; i < 100 && total_beats < t0 + B; i++) @(posedge clk_pixel);
    #2;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk_pixel); #2;
      if (mem_req) bad++;
    end
    check(bad == 0, "stall_free8", bad, 0);
    @(negedge clk_pixel);
    fifo_free = 11'd15;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_pixel); #2;
      if (mem_req) bad++;
    end
    check(bad == 0, "stall_free15", bad, 0);
    @(negedge clk_pixel);
    fifo_free = 11'd16;
    @(posedge clk_pixel); #2;
    check(mem_req == 1'b1 && mem_addr == 24'h001010, "credit_resume",
          {mem_req, mem_addr}, {1'b1, 24'h001010});

    // Late frame start while a slow request is outstanding.
    @(negedge clk_pixel);
    fifo_free = 11'd1024;
    ack_dly   = 20;
    fb_base   = 24'h002000;
    t0        = total_beats;
    jump_tok++;
    wait_flush(300, ok);
    check(ok, "late_flush_seen", ok, 1);
    check(late_cnt == 1, "late_once", late_cnt, 1);
    check(total_beats - t0 == B, "beats_drained", total_beats - t0, B);
    @(negedge clk_pixel);
    ack_dly = 3;
    wait_next_req(50, a, ok);
    check(ok && a == 24'h002000, "restart_at_base", a, 24'h002000);

    // Address wrap past the top of memory.
    @(negedge clk_pixel);
    fb_base = 24'hFFFF00;
    wait_flush(1500, ok);
    check(ok, "wrap_flush_seen", ok, 1);
    wait_next_req(50, a, ok);
    check(ok && a == 24'hFFFF00, "wrap_first", a, 24'hFFFF00);
    for (int i = 0; i < 3; i++) wait_next_req(200, a, ok);
    wait_next_req(200, a, ok);
`ifdef VGA_LINE_REPEAT_EN
    exp5 = 24'hFFFF00;
`else
    exp5 = 24'h000180;
`endif
    check(ok && a == exp5, "wrap_line1_start", a, exp5);
    bad = 0;
    for (int i = 0; i < BPF - 5; i++) begin
      wait_next_req(200, a, ok);
      if (!ok) bad++;
    end
    check(bad == 0 && k == BPF, "wrap_burst_count", k, BPF);
    wait_next_req(60, a, ok);
    check(!ok, "no_extra_req", ok, 0);
    check(late_cnt == 1, "wrap_no_late", late_cnt, 1);

    // Disabled at frame start: back to idle, no flush.
    @(negedge clk_pixel);
    enable = 1'b0;
    fc = flush_cnt;
    for (int i = 0; i < 1100; i++) begin
      @(posedge clk_pixel); #2;
      if (beam_x == 12'd0 && beam_y == 11'(Y)) break;
    end
    repeat (3) @(posedge clk_pixel);
    #2;
    check(busy == 1'b0 && flush_cnt == fc, "idle_after_disable", {busy, 8'(flush_cnt - fc)}, 0);
    @(negedge clk_pixel);
    enable  = 1'b1;
    ack_dly = 10;

    // Asynchronous reset in the middle of a request.
    wait_flush(1200, ok);
    check(ok, "pre_reset_flush_seen", ok, 1);
    wait_next_req(50, a, ok);
    @(posedge clk_pixel);
    #3;
    rst_n = 1'b0;
    #1;
    check(mem_req == 1'b0 && busy == 1'b0 && mem_addr == '0, "async_reset",
          {mem_addr, mem_req, busy}, 32'h0);
    repeat (2) @(negedge clk_pixel);
    rst_n   = 1'b1;
    ack_dly = 3;
    bad = 0;
    ok  = 0;
    for (int i = 0; i < 1200; i++) begin
      @(posedge clk_pixel); #2;
      if (fifo_flush) begin ok = 1; break; end
      if (mem_req || busy) bad++;
    end
    check(ok && bad == 0, "no_req_until_fs", bad, 0);
    wait_next_req(50, a, ok);
    check(ok && a == 24'hFFFF00, "post_reset_base", a, 24'hFFFF00);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
